// File: rtl/spi_drain_pkg.sv
// Shared constants for the receive-buffer drain / SPI master stage.
package spi_drain_pkg;
  localparam int NBYTES_DEF    = 32;
  localparam int AW_DEF        = 5;
  localparam int CLK_DIV_DEF   = 4;
  localparam int BITS_PER_BYTE = 8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_RDHI   = 3'd2;
  localparam state_t ST_LATCH  = 3'd3;
  localparam state_t ST_SHIFT  = 3'd4;
  localparam state_t ST_NEXT   = 3'd5;
  localparam state_t ST_FINISH = 3'd6;
endpackage

// File: rtl/spi_drain_master_sync.sv
// Two-flop synchroniser, clears to 0 on reset.
module sync_2ff (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_drain_master.sv
// Drains the receive buffer on FULL: reads each byte by address, shifts it out
// as an SPI mode-0 master, captures MISO, then pulses the buffer clear.
module spi_drain_master
  import spi_drain_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int NBYTES  = NBYTES_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FULL,
  output logic [AW-1:0] ADDR,
  output logic          READ,
  input  logic [7:0]    BYTEIN,
  output logic          BUF_CLR_N,
  output logic          SCLK,
  output logic          MOSI,
  input  logic          MISO,
  output logic          SS_N,
  output logic [7:0]    RX_BYTE,
  output logic          RX_VALID,
  output logic          BUSY,
  output logic          DONE
);
  localparam int              DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_TC = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0]   LAST   = AW'(NBYTES - 1);
  localparam logic [2:0]      LAST_BIT = 3'(BITS_PER_BYTE - 1);

  state_t        state;
  logic          full_s, armed;
  logic [1:0]    warm;
  logic [AW-1:0] idx;
  logic [6:0]    tx;
  logic [7:0]    rx;
  logic [2:0]    bitcnt;
  logic [DW-1:0] divcnt;

  sync_2ff u_full_sync (.gclk(CLK), .grst_n(RESET), .d(FULL), .q(full_s));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      warm      <= 2'b00;
      idx       <= '0;
      tx        <= '0;
      rx        <= '0;
      bitcnt    <= '0;
      divcnt    <= '0;
      ADDR      <= '0;
      READ      <= 1'b0;
      BUF_CLR_N <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      SS_N      <= 1'b1;
      RX_BYTE   <= '0;
      RX_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      RX_VALID  <= 1'b0;
      DONE      <= 1'b0;
      BUF_CLR_N <= 1'b1;
      // full_s reads 0 while the synchroniser refills after reset; that is not
      // a real low on FULL, so arming waits until both stages hold live data.
      warm <= {warm[0], 1'b1};
      if (warm[1] && !full_s) armed <= 1'b1;

      case (state)
        ST_IDLE: if (full_s && armed) begin
          idx   <= '0;
          ADDR  <= '0;
          SS_N  <= 1'b0;
          BUSY  <= 1'b1;
          armed <= 1'b0;
          state <= ST_SETUP;
        end
        ST_SETUP: begin
          READ  <= 1'b1;
          state <= ST_RDHI;
        end
        ST_RDHI: begin
          READ  <= 1'b0;
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          tx     <= BYTEIN[6:0];
          MOSI   <= BYTEIN[7];
          bitcnt <= '0;
          divcnt <= '0;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (divcnt == DIV_TC) begin
            divcnt <= '0;
            SCLK   <= ~SCLK;
            if (!SCLK) begin
              rx <= {rx[6:0], MISO};
            end else if (bitcnt == LAST_BIT) begin
              RX_BYTE  <= rx;
              RX_VALID <= 1'b1;
              state    <= ST_NEXT;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              MOSI   <= tx[6];
              tx     <= {tx[5:0], 1'b0};
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (idx == LAST) begin
            DONE      <= 1'b1;
            BUF_CLR_N <= 1'b0;
            state     <= ST_FINISH;
          end else begin
            idx   <= idx + 1'b1;
            ADDR  <= idx + 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_FINISH: begin
          SS_N  <= 1'b1;
          BUSY  <= 1'b0;
          MOSI  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_drain_master.sv
// Bench for spi_drain_master: two instances (CLK_DIV=4/NBYTES=32 and 1/2)
// checked every cycle against a frame-offset model plus directed literals.
module tb_spi_drain_master;
  localparam int CDA = 4, NBA = 32, CDB = 1, NBB = 2;

  typedef struct packed {
    logic ss_n, sclk, read, rxv, done, clr_n, busy, mchk, mosi;
    logic [4:0] addr;
  } exp_t;

  logic CLK = 1'b0, RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic full_a, read_a, clr_a, sclk_a, mosi_a, miso_a, ssn_a, rxv_a, busy_a, done_a;
  logic full_b, read_b, clr_b, sclk_b, mosi_b, miso_b, ssn_b, rxv_b, busy_b, done_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] rxb_a, rxb_b;
  logic [7:0] bytein_a = 8'h00, bytein_b = 8'h00;
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [2];

  assign miso_a = mosi_a;   // loopback
  assign miso_b = ~mosi_b;  // inverted loopback

  spi_drain_master #(.CLK_DIV(CDA), .NBYTES(NBA), .AW(5)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .FULL(full_a), .ADDR(addr_a), .READ(read_a),
    .BYTEIN(bytein_a), .BUF_CLR_N(clr_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .MISO(miso_a), .SS_N(ssn_a), .RX_BYTE(rxb_a), .RX_VALID(rxv_a),
    .BUSY(busy_a), .DONE(done_a));

  spi_drain_master #(.CLK_DIV(CDB), .NBYTES(NBB), .AW(5)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .FULL(full_b), .ADDR(addr_b), .READ(read_b),
    .BYTEIN(bytein_b), .BUF_CLR_N(clr_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .MISO(miso_b), .SS_N(ssn_b), .RX_BYTE(rxb_b), .RX_VALID(rxv_b),
    .BUSY(busy_b), .DONE(done_b));

  // buffer models: data latched on READ rising edge
  always @(posedge read_a) bytein_a <= mem_a[addr_a];
  always @(posedge read_b) bytein_b <= mem_b[addr_b[0]];

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input int w, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s dut%0d: got %0d expected %0d", nm, w, act, exp);
    end
  endtask

  // Expected outputs k cycles after SS_N fell (k=0 is the address setup cycle).
  function automatic exp_t model(input int w, input int k);
    int cd, nb, per, b, p, h;
    logic [7:0] d;
    exp_t e;
    cd = w ? CDB : CDA;
    nb = w ? NBB : NBA;
    per = 4 + 16 * cd;
    e = '0;
    e.clr_n = 1'b1;
    e.busy = 1'b1;
    if (k == nb * per) begin
      e.done = 1'b1;
      e.clr_n = 1'b0;
      e.addr = 5'(nb - 1);
      return e;
    end
    b = k / per;
    p = k % per;
    d = w ? mem_b[b] : mem_a[b];
    e.addr = 5'(b);
    e.read = (p == 1);
    if (p >= 3 && p < 3 + 16 * cd) begin
      h = (p - 3) / cd;
      e.sclk = h[0];
      e.mchk = 1'b1;
      e.mosi = d[7 - h / 2];
    end else if (p == 3 + 16 * cd) begin
      e.rxv = 1'b1;
      e.mchk = 1'b1;
      e.mosi = d[0];
    end
    return e;
  endfunction

  // monitors
  int rise_a = 0, rise_b = 0, rd_cnt_a = 0;
  logic [15:0] sh_a = 16'h0, sh_b = 16'h0;
  always @(posedge sclk_a) begin rise_a++; sh_a = {sh_a[14:0], mosi_a}; end
  always @(posedge sclk_b) begin rise_b++; sh_b = {sh_b[14:0], mosi_b}; end
  always @(posedge read_a) rd_cnt_a++;

  int kk [2] = '{-1, -1};
  logic [7:0] rxl [2] = '{8'h00, 8'h00};
  bit allow [2] = '{1'b0, 1'b0};
  int cyc = 0, done_cnt_a = 0, done_cnt_b = 0, clr_cnt_a = 0, clr_cnt_b = 0;
  int rv_cnt_a = 0, done_cyc_a = 0, rv_cyc_a = 0;
  logic [7:0] first_rx_a = 8'h00;
  logic c_ssn, c_sc, c_mo, c_rd, c_cl, c_rv, c_bs, c_dn;
  logic [4:0] c_ad;
  logic [7:0] c_rb;
  exp_t c_e;
  int c_per, c_nb;

  always @(negedge CLK) begin
    cyc++;
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (done_b) done_cnt_b++;
    if (!clr_a) clr_cnt_a++;
    if (!clr_b) clr_cnt_b++;
    if (rxv_a) begin
      rv_cnt_a++;
      rv_cyc_a = cyc;
      if (rv_cnt_a == 1) first_rx_a = rxb_a;
    end
    for (int w = 0; w < 2; w++) begin
      {c_ssn, c_sc, c_mo, c_rd, c_cl, c_rv, c_bs, c_dn} = (w == 1) ?
        {ssn_b, sclk_b, mosi_b, read_b, clr_b, rxv_b, busy_b, done_b} :
        {ssn_a, sclk_a, mosi_a, read_a, clr_a, rxv_a, busy_a, done_a};
      c_ad = (w == 1) ? addr_b : addr_a;
      c_rb = (w == 1) ? rxb_b : rxb_a;
      if (!RESET) begin
        kk[w] = -1;
        rxl[w] = 8'h00;
        chk("rst_ss_n", w, c_ssn, 1);   chk("rst_sclk", w, c_sc, 0);
        chk("rst_mosi", w, c_mo, 0);    chk("rst_read", w, c_rd, 0);
        chk("rst_clr_n", w, c_cl, 1);   chk("rst_addr", w, c_ad, 0);
        chk("rst_rx_byte", w, c_rb, 0); chk("rst_rx_valid", w, c_rv, 0);
        chk("rst_busy", w, c_bs, 0);    chk("rst_done", w, c_dn, 0);
      end else begin
        if (kk[w] < 0 && !c_ssn) begin
          chk("start_expected", w, allow[w], 1);
          allow[w] = 1'b0;
          kk[w] = 0;
        end
        if (kk[w] >= 0) begin
          c_per = 4 + 16 * ((w == 1) ? CDB : CDA);
          c_nb = (w == 1) ? NBB : NBA;
          c_e = model(w, kk[w]);
          chk("ss_n", w, c_ssn, c_e.ss_n);   chk("sclk", w, c_sc, c_e.sclk);
          chk("read", w, c_rd, c_e.read);    chk("rx_valid", w, c_rv, c_e.rxv);
          chk("done", w, c_dn, c_e.done);    chk("buf_clr_n", w, c_cl, c_e.clr_n);
          chk("busy", w, c_bs, c_e.busy);    chk("addr", w, c_ad, c_e.addr);
          if (c_e.mchk) chk("mosi", w, c_mo, c_e.mosi);
          if (c_e.rxv) rxl[w] = (w == 1) ? ~mem_b[kk[w] / c_per] : mem_a[kk[w] / c_per];
          chk("rx_byte", w, c_rb, rxl[w]);
          kk[w]++;
          if (kk[w] > c_nb * c_per) kk[w] = -1;
        end else begin
          chk("idle_sclk", w, c_sc, 0);   chk("idle_read", w, c_rd, 0);
          chk("idle_rx_valid", w, c_rv, 0); chk("idle_done", w, c_dn, 0);
          chk("idle_clr_n", w, c_cl, 1);  chk("idle_busy", w, c_bs, 0);
          chk("idle_mosi", w, c_mo, 0);   chk("idle_rx_byte", w, c_rb, rxl[w]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_frame(input int w);
    int lat;
    if (w == 1) full_b = 1'b0; else full_a = 1'b0;
    repeat (3) tick();
    allow[w] = 1'b1;
    if (w == 1) full_b = 1'b1; else full_a = 1'b1;
    lat = 0;
    while (((w == 1) ? ssn_b : ssn_a) && lat < 10) begin tick(); lat++; end
    tests++;
    if (lat < 2 || lat > 3) begin
      fails++;
      $display("FAIL start_latency dut%0d: got %0d cycles expected 2..3", w, lat);
    end
  endtask

  task automatic frame_len(input int w, output int len);
    len = 0;
    while (!((w == 1) ? ssn_b : ssn_a) && len < 4000) begin tick(); len++; end
  endtask

  initial begin
    int len, budget, dc, cc;
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(3 * i + 1);
    mem_b[0] = 8'hA5;
    mem_b[1] = 8'h3C;
    full_a = 1'b1;
    full_b = 1'b1;
    repeat (3) tick();
    chk("lit_rst_ss_n", 0, ssn_a, 1);
    chk("lit_rst_buf_clr_n", 0, clr_a, 1);
    RESET = 1'b1;
    repeat (20) tick();
    chk("no_start_full_held_a", 0, busy_a, 0);
    chk("no_start_full_held_b", 1, busy_b, 0);

    // full frame with loopback
    rise_a = 0;
    rd_cnt_a = 0;
    start_frame(0);
    frame_len(0, len);
    chk("frame_len", 0, len, 32 * 68 + 1);
    tick();
    chk("read_pulses", 0, rd_cnt_a, 32);
    chk("sclk_rises", 0, rise_a, 256);
    chk("done_cycles", 0, done_cnt_a, 1);
    chk("clr_low_cycles", 0, clr_cnt_a, 1);
    chk("rx_valid_pulses", 0, rv_cnt_a, 32);
    chk("done_minus_last_rv", 0, done_cyc_a - rv_cyc_a, 1);
    chk("first_rx_byte", 0, first_rx_a, 8'h01);
    chk("last_mosi_byte", 0, sh_a[7:0], 8'h5E);
    chk("last_rx_byte", 0, rxb_a, 8'h5E);

    // FULL stays high: no re-trigger, then a fresh low/high restarts
    repeat (30) tick();
    chk("no_retrigger_busy", 0, busy_a, 0);
    rise_a = 0;
    start_frame(0);
    budget = 0;
    while (rise_a < 43 && budget < 2000) begin tick(); budget++; end
    chk("reached_byte5_rise3", 0, rise_a, 43);
    dc = done_cnt_a;
    cc = clr_cnt_a;
    RESET = 1'b0;
    #1;
    chk("abort_ss_n", 0, ssn_a, 1);
    chk("abort_sclk", 0, sclk_a, 0);
    chk("abort_busy", 0, busy_a, 0);
    repeat (3) tick();
    RESET = 1'b1;
    repeat (20) tick();
    chk("abort_no_done", 0, done_cnt_a, dc);
    chk("abort_no_clr", 0, clr_cnt_a, cc);
    chk("abort_no_restart", 0, busy_a, 0);

    // CLK_DIV=1, two bytes, inverted loopback
    rise_b = 0;
    start_frame(1);
    frame_len(1, len);
    chk("frame_len", 1, len, 2 * 20 + 1);
    tick();
    chk("mosi_stream", 1, sh_b, 16'hA53C);
    chk("sclk_rises", 1, rise_b, 16);
    chk("last_rx_byte", 1, rxb_b, 8'hC3);
    chk("done_cycles", 1, done_cnt_b, 1);
    chk("clr_low_cycles", 1, clr_cnt_b, 1);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
